psum_accum_engine: RTL and testbench
====================================

PSUM_ACCUM_ENGINE -- requirements
Module: psum_accum_engine

Interface
REQ-001 SHALL have parameter COL, default 8, number of psum lanes per vector.
REQ-002 SHALL have parameter PSUM_BW, default 13, signed two's-complement width of each lane.
REQ-003 SHALL have parameter ADDR_W, default 11, psum SRAM address width.
REQ-004 SHALL have parameter SAT, default 1: 1 = saturating lane add, 0 = wrapping lane add.
REQ-005 SHALL have ports as follows. Reset is synchronous and active-high; the clock is clk.
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: OFIFO vector valid.
- in_ready, output, 1: engine accepts in_data this cycle.
- in_data, input, PSUM_BW*COL: incoming psum vector; lane i is at bits [i*PSUM_BW +: PSUM_BW].
- in_addr, input, ADDR_W: target psum address.
- in_first, input, 1: 1 = overwrite (first kij), 0 = accumulate.
- drain_start, input, 1: single-cycle pulse that requests readout.
- drain_base, input, ADDR_W: first drain address.
- drain_len, input, ADDR_W: number of words to drain.
- relu_en, input, 1: apply per-lane ReLU on drain output.
- out_valid, output, 1: drain data valid.
- out_data, output, PSUM_BW*COL: drained vector.
- out_last, output, 1: final drained word.
- drain_done, output, 1: single-cycle completion pulse.
- busy, output, 1: engine not idle.
- sat_flag, output, 1: sticky flag, set when any lane saturated.
- mem_CEN, output, 1: SRAM chip enable, active-low.
- mem_WEN, output, 1: SRAM write enable, active-low.
- mem_A, output, ADDR_W: SRAM address.
- mem_D, output, PSUM_BW*COL: SRAM write data.
- mem_Q, input, PSUM_BW*COL: SRAM read data, valid 1 cycle after a read.

Function
REQ-006 SHALL implement FSM states IDLE, DRAIN_RD, DRAIN_FLUSH; accumulation traffic is accepted only in IDLE.
REQ-007 SHALL drive in_ready = (state==IDLE) && !wr_pending && !drain_start.
REQ-008 On an overwrite accept (in_valid && in_ready && in_first), SHALL write in_data to in_addr in the same cycle: mem_CEN=0, mem_WEN=0.
REQ-009 On an accumulate accept (in_valid && in_ready && !in_first), SHALL issue a read of in_addr in the same cycle (mem_CEN=0, mem_WEN=1), latch in_data and in_addr, and set wr_pending.
REQ-010 In the cycle after an accumulate accept, SHALL write the lane-wise sum mem_Q + latched data to the latched address, then clear wr_pending; throughput is one accumulate per 2 cycles.
REQ-011 With SAT=1, SHALL clamp each lane sum to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1] and set sat_flag on any clamp; with SAT=0, SHALL truncate each sum to PSUM_BW bits and leave sat_flag at 0.
REQ-012 When no access is issued, SHALL drive mem_CEN=1, mem_WEN=1, mem_A=0, mem_D=0.
REQ-013 SHALL honour drain_start only in IDLE with wr_pending=0; otherwise SHALL ignore it. A drain_start arriving while a write is pending SHALL be ignored, not queued.
REQ-014 On an accepted drain_start, SHALL latch drain_base and drain_len and clear sat_flag. If drain_len=0, SHALL stay in IDLE and pulse drain_done the next cycle. Otherwise SHALL enter DRAIN_RD.
REQ-015 In DRAIN_RD, SHALL issue one read per cycle at drain_base+k for k=0..drain_len-1, with the address wrapping modulo 2^ADDR_W. After the last read, SHALL enter DRAIN_FLUSH.
REQ-016 SHALL assert out_valid 1 cycle after each drain read, with out_data = mem_Q. When relu_en=1, any negative lane SHALL be replaced by 0. relu_en is sampled per word.
REQ-017 SHALL assert out_last together with out_valid for the final word. SHALL pulse drain_done in DRAIN_FLUSH, then return to IDLE.
REQ-018 Drain output has no backpressure; the consumer SHALL accept one word per cycle.
REQ-019 SHALL drive busy = (state!=IDLE) || wr_pending.
REQ-020 in_first is ignored when no accept occurs. An address collision between consecutive accepts is safe, because each write completes before the next read.

Reset
REQ-021 While reset=1, SHALL set state=IDLE and clear wr_pending, sat_flag, out_valid, out_last, drain_done and busy. in_ready SHALL be 0 during reset, and mem_CEN=1 and mem_WEN=1.
REQ-022 Reset during accumulation or drain SHALL abort the operation: the pending write is dropped and no further SRAM access is issued.

Verification
REQ-023 Overwrite then accumulate: in_first=1 writes all lanes=5 to addr 3; then in_first=0 with lanes=7 at addr 3; then drain base=3, len=1 -> out_data all lanes 12, out_last=1.
REQ-024 Saturation: SAT=1, addr 0 holds lane0=4000; accumulate lane0=500 -> stored value 4095, sat_flag=1. With SAT=0 the same stimulus -> stored value (4500 mod 8192) sign-interpreted = -3692, sat_flag=0.
REQ-025 Back-to-back: in_valid held high for 4 accumulate vectors -> in_ready pattern 1,0,1,0,1,0,1; exactly 4 writes occur.
REQ-026 Drain wrap: base=2046, len=4, ADDR_W=11 -> reads at 2046, 2047, 0, 1; out_last on the 4th word; drain_done 1 cycle after the last out_valid.
REQ-027 ReLU plus boundaries: word with lanes -3 and 9, relu_en=1 -> 0 and 9. drain_len=0 -> no out_valid, drain_done pulse only. drain_start while busy -> ignored.
REQ-028 Reset mid-drain after 2 of 5 words -> out_valid=0 next cycle, busy=0, state=IDLE, no drain_done pulse.

Source files
------------

// File: rtl/psum_accum_engine.sv
// Partial-sum accumulation engine.
// Incoming psum vectors either overwrite an SRAM word or are added to it
// lane by lane, using a one-cycle read followed by a one-cycle write.
// A drain pass streams a range of words out, with optional per-lane ReLU.
//
// Handshake: an input vector transfers on a clock edge where in_valid and
// in_ready are both high. The drain output has no backpressure: a word is
// delivered on every cycle that out_valid is high.
module psum_accum_engine #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 13,
    parameter int ADDR_W  = 11,
    parameter int SAT     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PSUM_BW*COL-1:0]    in_data,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic                      in_first,
    input  logic                      drain_start,
    input  logic [ADDR_W-1:0]         drain_base,
    input  logic [ADDR_W-1:0]         drain_len,
    input  logic                      relu_en,
    output logic                      out_valid,
    output logic [PSUM_BW*COL-1:0]    out_data,
    output logic                      out_last,
    output logic                      drain_done,
    output logic                      busy,
    output logic                      sat_flag,
    output logic                      mem_CEN,
    output logic                      mem_WEN,
    output logic [ADDR_W-1:0]         mem_A,
    output logic [PSUM_BW*COL-1:0]    mem_D,
    input  logic [PSUM_BW*COL-1:0]    mem_Q
);

    localparam int VW = PSUM_BW * COL;
    localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PSUM_BW-1:0] LANE_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] LANE_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DRAIN_RD    = 2'd1,
        DRAIN_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                wr_pending_q, wr_pending_d;
    logic [VW-1:0]       lat_data_q, lat_data_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [ADDR_W-1:0]   drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                sat_flag_q, sat_flag_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                drain_done_q, drain_done_d;

    logic [VW-1:0]       sum_vec;
    logic [VW-1:0]       relu_vec;
    logic [COL-1:0]      lane_ovf;

    // Per-lane adder (read data + latched vector) and per-lane ReLU on read data.
    for (genvar g = 0; g < COL; g++) begin : g_lane
        logic [PSUM_BW-1:0] a;
        logic [PSUM_BW-1:0] b;
        logic [PSUM_BW:0]   s;
        assign a = mem_Q[g*PSUM_BW +: PSUM_BW];
        assign b = lat_data_q[g*PSUM_BW +: PSUM_BW];
        assign s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (SAT != 0) begin : g_sat
            // Signed overflow shows as disagreement of the two top bits.
            assign lane_ovf[g] = s[PSUM_BW] ^ s[PSUM_BW-1];
            assign sum_vec[g*PSUM_BW +: PSUM_BW] =
                !lane_ovf[g] ? s[PSUM_BW-1:0] : (s[PSUM_BW] ? LANE_MIN : LANE_MAX);
        end else begin : g_wrap
            assign lane_ovf[g] = 1'b0;
            assign sum_vec[g*PSUM_BW +: PSUM_BW] = s[PSUM_BW-1:0];
        end
        assign relu_vec[g*PSUM_BW +: PSUM_BW] =
            (relu_en && a[PSUM_BW-1]) ? '0 : a;
    end

    // Next-state, SRAM command and handshake logic; everything is held quiet in reset.
    always_comb begin
        state_d      = state_q;
        wr_pending_d = wr_pending_q;
        lat_data_d   = lat_data_q;
        lat_addr_d   = lat_addr_q;
        drain_addr_d = drain_addr_q;
        drain_cnt_d  = drain_cnt_q;
        sat_flag_d   = sat_flag_q;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        drain_done_d = 1'b0;
        in_ready     = 1'b0;
        mem_CEN      = 1'b1;
        mem_WEN      = 1'b1;
        mem_A        = '0;
        mem_D        = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    in_ready = !wr_pending_q && !drain_start;
                    if (wr_pending_q) begin
                        // Second half of an accumulate: write back the lane sums.
                        mem_CEN      = 1'b0;
                        mem_WEN      = 1'b0;
                        mem_A        = lat_addr_q;
                        mem_D        = sum_vec;
                        wr_pending_d = 1'b0;
                        if (|lane_ovf) sat_flag_d = 1'b1;
                    end else if (drain_start) begin
                        drain_addr_d = drain_base;
                        drain_cnt_d  = drain_len;
                        sat_flag_d   = 1'b0;
                        if (drain_len == '0) drain_done_d = 1'b1;
                        else                 state_d      = DRAIN_RD;
                    end else if (in_valid) begin
                        mem_CEN = 1'b0;
                        mem_A   = in_addr;
                        if (in_first) begin
                            mem_WEN = 1'b0;
                            mem_D   = in_data;
                        end else begin
                            lat_data_d   = in_data;
                            lat_addr_d   = in_addr;
                            wr_pending_d = 1'b1;
                        end
                    end
                end
                DRAIN_RD: begin
                    mem_CEN      = 1'b0;
                    mem_A        = drain_addr_q;
                    drain_addr_d = drain_addr_q + ADDR_ONE;
                    drain_cnt_d  = drain_cnt_q - ADDR_ONE;
                    out_valid_d  = 1'b1;
                    if (drain_cnt_q == ADDR_ONE) begin
                        out_last_d = 1'b1;
                        state_d    = DRAIN_FLUSH;
                    end
                end
                DRAIN_FLUSH: begin
                    drain_done_d = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_pending_q <= 1'b0;
            lat_data_q   <= '0;
            lat_addr_q   <= '0;
            drain_addr_q <= '0;
            drain_cnt_q  <= '0;
            sat_flag_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_pending_q <= wr_pending_d;
            lat_data_q   <= lat_data_d;
            lat_addr_q   <= lat_addr_d;
            drain_addr_q <= drain_addr_d;
            drain_cnt_q  <= drain_cnt_d;
            sat_flag_q   <= sat_flag_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_valid_q ? relu_vec : '0;
    assign drain_done = drain_done_q;
    assign sat_flag   = sat_flag_q;
    assign busy       = !reset && ((state_q != IDLE) || wr_pending_q);

endmodule

// File: tb/tb_psum_accum_engine.sv
// Bench for psum_accum_engine: a saturating and a wrapping instance share all
// inputs, each backed by its own SRAM model; drained words are scored against
// a reference memory model.
`timescale 1ns/1ps
module tb_psum_accum_engine;
  localparam int COL = 8;
  localparam int BW = 13;
  localparam int AW = 11;
  localparam int VW = COL * BW;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic in_valid, in_first, drain_start, relu_en;
  logic [VW-1:0] in_data;
  logic [AW-1:0] in_addr, drain_base, drain_len;

  logic in_ready1, out_valid1, out_last1, drain_done1, busy1, sat_flag1, cen1, wen1;
  logic [AW-1:0] a1;
  logic [VW-1:0] d1, q1, out_data1;
  logic in_ready0, out_valid0, out_last0, drain_done0, busy0, sat_flag0, cen0, wen0;
  logic [AW-1:0] a0;
  logic [VW-1:0] d0, q0, out_data0;

  logic [VW-1:0] mem1 [DEPTH];
  logic [VW-1:0] mem0 [DEPTH];
  logic [VW-1:0] ref_mem [DEPTH];

  psum_accum_engine #(.COL(COL), .PSUM_BW(BW), .ADDR_W(AW), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_addr(in_addr), .in_first(in_first),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .relu_en(relu_en), .out_valid(out_valid1), .out_data(out_data1),
    .out_last(out_last1), .drain_done(drain_done1), .busy(busy1),
    .sat_flag(sat_flag1), .mem_CEN(cen1), .mem_WEN(wen1), .mem_A(a1),
    .mem_D(d1), .mem_Q(q1));

  psum_accum_engine #(.COL(COL), .PSUM_BW(BW), .ADDR_W(AW), .SAT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_addr(in_addr), .in_first(in_first),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .relu_en(relu_en), .out_valid(out_valid0), .out_data(out_data0),
    .out_last(out_last0), .drain_done(drain_done0), .busy(busy0),
    .sat_flag(sat_flag0), .mem_CEN(cen0), .mem_WEN(wen0), .mem_A(a0),
    .mem_D(d0), .mem_Q(q0));

  // SRAM models: write on !CEN&!WEN, registered read data otherwise.
  always @(posedge clk) begin
    if (!cen1) begin
      if (!wen1) mem1[a1] <= d1;
      else       q1 <= mem1[a1];
    end
    if (!cen0) begin
      if (!wen0) mem0[a0] <= d0;
      else       q0 <= mem0[a0];
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [VW-1:0] model_acc(input logic [VW-1:0] o, input logic [VW-1:0] a);
    logic [VW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      s = int'($signed(o[i*BW +: BW])) + int'($signed(a[i*BW +: BW]));
      if (s > 4095) s = 4095;
      if (s < -4096) s = -4096;
      r[i*BW +: BW] = s[BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] model_relu(input logic [VW-1:0] w, input logic en);
    logic [VW-1:0] r;
    r = w;
    for (int i = 0; i < COL; i++)
      if (en && w[i*BW + BW - 1]) r[i*BW +: BW] = '0;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom_range(0, 8191));
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [VW:0] exp_q[$];
  logic [AW-1:0] rd_log[$];
  logic log_en = 1'b0;
  int cyc = 0, wr_cnt = 0, out_cnt = 0, done_cnt = 0;
  int last_out_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    logic [VW:0] e;
    cyc++;
    if (!cen1 && !wen1) wr_cnt++;
    if (log_en && !cen1 && wen1) rd_log.push_back(a1);
    if (out_valid1) begin
      out_cnt++;
      if (exp_q.size() == 0) check("out_unexpected", out_valid1, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("out_data", out_data1, e[VW-1:0]);
        check("out_last", out_last1, e[VW]);
      end
      if (out_last1) last_out_cyc = cyc;
    end
    if (drain_done1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [AW-1:0] addr, input logic [VW-1:0] data, input logic first);
    int n;
    n = 0;
    in_valid = 1'b1; in_addr = addr; in_data = data; in_first = first;
    sample();
    while (!in_ready1 && n < 20) begin sample(); n++; end
    check("send_accept", in_ready1, 1'b1);
    tick();
    in_valid = 1'b0;
    ref_mem[addr] = first ? data : model_acc(ref_mem[addr], data);
    tick();
  endtask

  task automatic drain(input logic [AW-1:0] base, input logic [AW-1:0] len,
                       input logic relu, input string tag, input logic poke);
    int n, oc0, dc0;
    for (int k = 0; k < int'(len); k++)
      exp_q.push_back({(k == int'(len) - 1), model_relu(ref_mem[(int'(base) + k) % DEPTH], relu)});
    oc0 = out_cnt; dc0 = done_cnt;
    relu_en = relu; drain_base = base; drain_len = len; drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    if (poke) begin
      tick();
      drain_base = 11'd500; drain_len = 11'd3; drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
    end
    n = 0;
    while (done_cnt == dc0 && n < int'(len) + 10) begin sample(); n++; end
    check({tag, "_done_cnt"}, done_cnt - dc0, 1);
    check({tag, "_words"}, out_cnt - oc0, int'(len));
    check({tag, "_q_empty"}, exp_q.size(), 0);
    if (len == '0) check({tag, "_done_lat"}, n, 1);
    else           check({tag, "_done_gap"}, done_cyc - last_out_cyc, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    logic [6:0] pat;
    int n, k, oc0, dc0, w0;
    logic acc;

    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = '0; mem0[i] = '0; ref_mem[i] = '0;
    end
    q1 = '0; q0 = '0;
    reset = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_addr = 11'd7; in_data = '1;
    drain_start = 1'b0; drain_base = '0; drain_len = '0; relu_en = 1'b0;
    repeat (3) tick();
    sample();
    check("rst_in_ready", in_ready1, 1'b0);
    check("rst_cen", cen1, 1'b1);
    check("rst_wen", wen1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_out_valid", out_valid1, 1'b0);
    check("rst_done", drain_done1, 1'b0);
    check("rst_sat", sat_flag1, 1'b0);
    check("rst_state", dut1.state_q, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("idle_in_ready", in_ready1, 1'b1);

    // Overwrite then accumulate, drain one word.
    send(11'd3, {COL{13'd5}}, 1'b1);
    send(11'd3, {COL{13'd7}}, 1'b0);
    check("ow_acc_mem", mem1[3], {COL{13'd12}});
    drain(11'd3, 11'd1, 1'b0, "ow_acc", 1'b0);

    // Saturation versus wrap.
    v = '0; v[BW-1:0] = 13'd4000;
    send(11'd0, v, 1'b1);
    v = '0; v[BW-1:0] = 13'd500;
    send(11'd0, v, 1'b0);
    check("sat_lane0", mem1[0][BW-1:0], 13'd4095);
    check("sat_flag_set", sat_flag1, 1'b1);
    check("wrap_lane0", mem0[0][BW-1:0], 13'd4500);
    check("wrap_flag", sat_flag0, 1'b0);
    drain(11'd0, 11'd1, 1'b0, "sat", 1'b0);
    check("sat_flag_clr", sat_flag1, 1'b0);

    // Back-to-back accumulates with in_valid held high.
    wr_cnt = 0; k = 0; n = 0; pat = '0;
    in_valid = 1'b1; in_first = 1'b0; in_addr = 11'd40; in_data = rand_vec();
    while (k < 4 && n < 20) begin
      sample();
      pat = {pat[5:0], in_ready1};
      acc = in_ready1;
      n++;
      tick();
      if (acc) begin
        ref_mem[in_addr] = model_acc(ref_mem[in_addr], in_data);
        k++;
        if (k < 4) begin in_addr = in_addr + 11'd1; in_data = rand_vec(); end
        else in_valid = 1'b0;
      end
    end
    tick();
    check("b2b_ready_pat", pat, 7'b1010101);
    check("b2b_cycles", n, 7);
    check("b2b_writes", wr_cnt, 4);
    drain(11'd40, 11'd4, 1'b0, "b2b", 1'b0);

    // Address wrap, with an ignored drain_start poked mid-drain.
    for (int i = 0; i < 4; i++) send(AW'(2046 + i), rand_vec(), 1'b1);
    rd_log.delete();
    log_en = 1'b1;
    drain(11'd2046, 11'd4, 1'b0, "wrap", 1'b1);
    log_en = 1'b0;
    check("wrap_rd_n", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("wrap_rd0", rd_log[0], 11'd2046);
      check("wrap_rd1", rd_log[1], 11'd2047);
      check("wrap_rd2", rd_log[2], 11'd0);
      check("wrap_rd3", rd_log[3], 11'd1);
    end

    // ReLU: lane0 = -3, lane1 = 9.
    v = rand_vec(); v[BW-1:0] = 13'h1FFD; v[2*BW-1:BW] = 13'd9;
    send(11'd20, v, 1'b1);
    drain(11'd20, 11'd1, 1'b1, "relu", 1'b0);

    // Zero-length drain.
    drain(11'd20, 11'd0, 1'b0, "len0", 1'b0);

    // drain_start while a write is pending is dropped.
    oc0 = out_cnt; dc0 = done_cnt;
    in_valid = 1'b1; in_first = 1'b0; in_addr = 11'd5; in_data = rand_vec();
    tick();
    ref_mem[5] = model_acc(ref_mem[5], in_data);
    in_valid = 1'b0; drain_base = 11'd5; drain_len = 11'd2; drain_start = 1'b1;
    sample();
    check("pend_busy", busy1, 1'b1);
    check("pend_in_ready", in_ready1, 1'b0);
    tick();
    drain_start = 1'b0;
    repeat (6) tick();
    check("pend_no_out", out_cnt - oc0, 0);
    check("pend_no_done", done_cnt - dc0, 0);
    check("pend_idle", busy1, 1'b0);

    // Random mixed traffic, then drain the region.
    for (int i = 0; i < 12; i++)
      send(AW'(100 + $urandom_range(0, 7)), rand_vec(), 1'($urandom_range(0, 1)));
    drain(11'd100, 11'd8, 1'($urandom_range(0, 1)), "rand", 1'b0);

    // Reset in the middle of a 5-word drain.
    for (int i = 0; i < 5; i++) send(AW'(30 + i), rand_vec(), 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), ref_mem[30 + i]});
    oc0 = out_cnt; dc0 = done_cnt;
    relu_en = 1'b0; drain_base = 11'd30; drain_len = 11'd5; drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    n = 0;
    while (out_cnt - oc0 < 2 && n < 20) begin sample(); n++; end
    reset = 1'b1;
    w0 = wr_cnt;
    sample();
    check("mid_rst_out_valid", out_valid1, 1'b0);
    check("mid_rst_busy", busy1, 1'b0);
    check("mid_rst_state", dut1.state_q, 0);
    check("mid_rst_cen", cen1, 1'b1);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("mid_rst_words", out_cnt - oc0, 2);
    check("mid_rst_no_done", done_cnt - dc0, 0);
    check("mid_rst_no_wr", wr_cnt - w0, 0);
    check("mid_rst_ready", in_ready1, 1'b1);
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
